// File: rtl/tnn_popcount_seq_if.sv
// tnn_popcount_seq_if: chunk input, shared popcount and result handshake bundle.
interface tnn_popcount_seq_if #(parameter int ACC_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [24:0]       in_x;
    logic [24:0]       in_wp;
    logic [24:0]       in_wn;
    logic [24:0]       pc_a;
    logic [4:0]        pc_q;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W:0]    out_sum;
    logic [1:0]        out_act;
    modport master (
        output in_valid, in_x, in_wp, in_wn, pc_q, out_ready,
        input  in_ready, pc_a, out_valid, out_sum, out_act
    );
    modport slave (
        input  in_valid, in_x, in_wp, in_wn, pc_q, out_ready,
        output in_ready, pc_a, out_valid, out_sum, out_act
    );
endinterface

// File: rtl/tnn_popcount_seq.sv
// tnn_popcount_seq: time-shares one popcount unit to evaluate a ternary neuron over NBEATS chunks.
module tnn_popcount_seq #(
    parameter int NBEATS = 4,
    parameter int ACC_W  = 8,
    parameter int THR_HI = 2,
    parameter int THR_LO = -2
) (
    input logic clk,
    input logic rst,
    tnn_popcount_seq_if.slave bus
);
    localparam int BW = NBEATS > 1 ? $clog2(NBEATS) : 1;
    localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(THR_HI);
    localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(THR_LO);
    typedef enum logic [1:0] {ACCEPT, POS, NEG, DONE} state_t;
    state_t                  state;
    logic [BW-1:0]           beat;
    logic [ACC_W-1:0]        acc_p, acc_n, sat_v;
    logic [24:0]             opp, opn;
    logic [ACC_W:0]          sum;
    logic signed [ACC_W:0]   diff;
    logic                    last;
    // one saturating adder serves both accumulators; POS selects acc_p, NEG acc_n
    always_comb begin
        sum   = {1'b0, state == POS ? acc_p : acc_n} + (ACC_W+1)'(bus.pc_q);
        sat_v = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        diff  = $signed({1'b0, acc_p}) - $signed({1'b0, acc_n});
        last  = beat == BW'(NBEATS - 1);
    end
    assign bus.in_ready  = !rst && state == ACCEPT;
    assign bus.out_valid = !rst && state == DONE;
    assign bus.pc_a      = rst ? '0 : state == POS ? opp : state == NEG ? opn : '0;
    assign bus.out_sum   = rst ? '0 : diff;
    assign bus.out_act   = rst ? 2'b00 : diff >= HI ? 2'b01 : diff <= LO ? 2'b11 : 2'b00;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCEPT;
            beat  <= '0;
            acc_p <= '0;
            acc_n <= '0;
            opp   <= '0;
            opn   <= '0;
        end else begin
            case (state)
                ACCEPT: if (bus.in_valid) begin
                    opp   <= bus.in_x & bus.in_wp;
                    opn   <= bus.in_x & bus.in_wn;
                    state <= POS;
                end
                POS: begin
                    acc_p <= sat_v;
                    state <= NEG;
                end
                NEG: begin
                    acc_n <= sat_v;
                    beat  <= last ? '0 : beat + 1'b1;
                    state <= last ? DONE : ACCEPT;
                end
                DONE: if (bus.out_ready) begin
                    acc_p <= '0;
                    acc_n <= '0;
                    state <= ACCEPT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tnn_popcount_seq.sv
// tb_tnn_popcount_seq: randomized scenarios checked against an arithmetic neuron model.
module tb_tnn_popcount_seq;
    localparam int NB = 4;
    localparam int AW = 8;
    logic clk = 0;
    logic rst = 1;
    logic force31 = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_hs = 0;
    int   ph = 0;
    logic [24:0] mp, mn, pe;
    logic [24:0] bx[NB], bp[NB], bn[NB];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    tnn_popcount_seq_if #(.ACC_W(AW)) bus();
    tnn_popcount_seq_if #(.ACC_W(6))  bus6();
    assign bus.pc_q  = (force31 && bus.pc_a != 0) ? 5'd31 : 5'($countones(bus.pc_a));
    assign bus6.pc_q = (bus6.pc_a != 0) ? 5'd31 : 5'd0;
    tnn_popcount_seq #(.NBEATS(NB), .ACC_W(AW), .THR_HI(2), .THR_LO(-2)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    tnn_popcount_seq #(.NBEATS(NB), .ACC_W(6), .THR_HI(2), .THR_LO(-2)) dut6 (
        .clk(clk), .rst(rst), .bus(bus6.slave));

    function automatic int pcnt(logic [24:0] v);
        return (force31 && v != 0) ? 31 : $countones(v);
    endfunction
    function automatic int ref_sum(int aw);
        int p = 0, n = 0, lim = (1 << aw) - 1;
        for (int i = 0; i < NB; i++) begin
            p += pcnt(bx[i] & bp[i]);
            n += pcnt(bx[i] & bn[i]);
        end
        return (p > lim ? lim : p) - (n > lim ? lim : n);
    endfunction
    function automatic logic [1:0] ref_act(int s);
        return s >= 2 ? 2'b01 : s <= -2 ? 2'b11 : 2'b00;
    endfunction

    // operand gating: pc_a follows captured chunks through POS/NEG and is 0 otherwise
    always @(negedge clk) begin
        pe = rst ? '0 : ph == 1 ? mp : ph == 2 ? mn : '0;
        checks++;
        if (bus.pc_a !== pe) begin
            errors++;
            $display("FAIL pc_a cycle %0d: got %h required %h", cyc, bus.pc_a, pe);
        end
        checks++;
        if (bus.in_ready === 1'b1 && bus.out_valid === 1'b1) begin
            errors++;
            $display("FAIL exclusive cycle %0d: in_ready and out_valid both 1", cyc);
        end
        if (rst) ph = 0;
        else if (ph == 1) ph = 2;
        else if (ph == 2) ph = 0;
        else if (bus.in_valid && bus.in_ready) begin
            ph = 1;
            mp = bus.in_x & bus.in_wp;
            mn = bus.in_x & bus.in_wn;
        end
    end

    task automatic fill(logic [24:0] x, logic [24:0] wp, logic [24:0] wn);
        for (int i = 0; i < NB; i++) begin
            bx[i] = x;
            bp[i] = wp;
            bn[i] = wn;
        end
    endtask
    task automatic fill_rand();
        for (int i = 0; i < NB; i++) begin
            bx[i] = 25'($urandom);
            bp[i] = 25'($urandom);
            bn[i] = 25'($urandom);
        end
    endtask

    task automatic send_chunk(int i, int gap);
        int n = 0;
        bus.in_valid = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1;
        bus.in_x = bx[i];
        bus.in_wp = bp[i];
        bus.in_wn = bn[i];
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept chunk %0d: in_ready=%b required 1", i, bus.in_ready);
        end
        last_hs = cyc;
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        bus.in_x = 25'($urandom);
        bus.in_wp = 25'($urandom);
        bus.in_wn = 25'($urandom);
    endtask

    task automatic run_neuron(string name, int maxgap, int hold, bit pre);
        int es, n;
        logic [1:0] ea, a;
        logic [AW:0] s;
        es = ref_sum(AW);
        ea = ref_act(es);
        for (int i = 0; i < NB; i++) send_chunk(i, $urandom_range(0, maxgap));
        bus.out_ready = pre;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid timeout: got %b required 1", name, bus.out_valid);
        end
        checks++;
        if (cyc !== last_hs + 3) begin
            errors++;
            $display("FAIL %s latency: got %0d required 3", name, cyc - last_hs);
        end
        checks++;
        if (int'($signed(bus.out_sum)) !== es) begin
            errors++;
            $display("FAIL %s out_sum: got %0d required %0d", name, $signed(bus.out_sum), es);
        end
        checks++;
        if (bus.out_act !== ea) begin
            errors++;
            $display("FAIL %s out_act: got %b required %b", name, bus.out_act, ea);
        end
        s = bus.out_sum;
        a = bus.out_act;
        if (!pre) begin
            repeat (hold) begin
                @(negedge clk);
                checks++;
                if (!(bus.out_valid === 1'b1 && bus.out_sum === s && bus.out_act === a)) begin
                    errors++;
                    $display("FAIL %s hold: valid=%b sum=%h act=%b required 1 %h %b",
                             name, bus.out_valid, bus.out_sum, bus.out_act, s, a);
                end
            end
            @(posedge clk);
            #1 bus.out_ready = 1;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s done held: out_valid=%b required 1", name, bus.out_valid);
            end
        end
        @(posedge clk);
        #1 bus.out_ready = 0;
        @(negedge clk);
        checks++;
        if (!(bus.in_ready === 1'b1 && bus.out_valid === 1'b0)) begin
            errors++;
            $display("FAIL %s after done: in_ready=%b out_valid=%b required 1 0",
                     name, bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(string name);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.pc_a, bus.out_sum, bus.out_act} !== '0) begin
            errors++;
            $display("FAIL %s: ready=%b valid=%b pc_a=%h sum=%h act=%b required all 0",
                     name, bus.in_ready, bus.out_valid, bus.pc_a, bus.out_sum, bus.out_act);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if (!(bus.in_ready === 1'b1 && bus.out_valid === 1'b0 && bus.out_sum === '0)) begin
            errors++;
            $display("FAIL post-reset: ready=%b valid=%b sum=%h required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.out_sum);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mixed();
        fill('1, 25'h1F, 25'h7);
        run_neuron("mixed", 0, 0, 0);
    endtask

    task automatic test_bands();
        fill('1, 25'h0, 25'h1);
        run_neuron("negative", 0, 2, 0);
        fill('1, 25'h3, 25'h3);
        run_neuron("zero", 0, 2, 0);
        fill('1, 25'h0, 25'h0);
        bp[0] = 25'h1;
        bp[1] = 25'h1;
        run_neuron("threshold", 0, 2, 0);
    endtask

    task automatic test_saturation();
        int e6, n = 0;
        force31 = 1;
        fill('1, 25'h1, 25'h0);
        run_neuron("sat31", 0, 0, 0);
        fill('1, '1, 25'h0);
        e6 = ref_sum(6);
        force31 = 0;
        bus6.in_x = '1;
        bus6.in_wp = '1;
        bus6.in_wn = '0;
        bus6.in_valid = 1;
        @(negedge clk);
        while (!bus6.out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        bus6.in_valid = 0;
        repeat (3) begin
            checks++;
            if (!(bus6.out_valid === 1'b1 && int'($signed(bus6.out_sum)) === e6 && bus6.out_act === 2'b01)) begin
                errors++;
                $display("FAIL sat6: valid=%b sum=%0d act=%b required 1 %0d 01",
                         bus6.out_valid, $signed(bus6.out_sum), bus6.out_act, e6);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_handshake_stress();
        repeat (4) begin
            fill_rand();
            run_neuron("stress", 4, 10, 0);
        end
    endtask

    task automatic test_back_to_back();
        repeat (3) begin
            fill_rand();
            run_neuron("b2b", 0, 0, 1);
        end
    endtask

    task automatic test_reset_mid();
        fill_rand();
        for (int i = 0; i < 3; i++) send_chunk(i, 0);
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        check_reset_outputs("mid-reset");
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid-reset recover: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        fill('1, 25'h1F, 25'h7);
        run_neuron("after-reset", 0, 0, 0);
    endtask

    task automatic test_operand();
        repeat (250) begin
            fill_rand();
            run_neuron("operand", 1, 0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_x = '0;
        bus.in_wp = '0;
        bus.in_wn = '0;
        bus.out_ready = 0;
        bus6.in_valid = 0;
        bus6.in_x = '0;
        bus6.in_wp = '0;
        bus6.in_wn = '0;
        bus6.out_ready = 0;
        test_reset();
        test_mixed();
        test_bands();
        test_saturation();
        test_handshake_stress();
        test_back_to_back();
        test_reset_mid();
        test_operand();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tnn_popcount_seq.md
# tnn_popcount_seq

Sequencer that time-shares one 25-input popcount unit (exact or approximate `popcount25_*` variant) to evaluate one ternary neuron over `NBEATS` 25-bit input chunks. For each chunk it runs the popcount twice: once on the positive-weight mask and once on the negative-weight mask. It accumulates both counts with saturation and emits the signed difference plus a ternary activation over a valid/ready handshake. It sits between the input-vector streamer and the activation register file of a printed TNN layer.

## Interface
- `NBEATS`, 4: number of 25-bit chunks per neuron evaluation (≥1).
- `ACC_W`, 8: width of each unsigned accumulator.
- `THR_HI`, 2: signed threshold; `out_sum >= THR_HI` gives activation +1.
- `THR_LO`, -2: signed threshold; `out_sum <= THR_LO` gives activation −1. Requires `THR_LO < THR_HI`.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  chunk available.
- `in_ready`  out  1  block accepts a chunk this cycle.
- `in_x`  in  25  ternary-encoded input activations (1 = active).
- `in_wp`  in  25  positive-weight mask.
- `in_wn`  in  25  negative-weight mask.
- `pc_a`  out  25  operand driven to the shared popcount unit.
- `pc_q`  in  5  popcount result, combinational from `pc_a`, same cycle.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `out_sum`  out  ACC_W+1  signed `acc_p − acc_n`, two's complement.
- `out_act`  out  2  ternary activation: 01 = +1, 00 = 0, 11 = −1.

## Operation
- Reset is synchronous, active-high, and fixed: on a `rst` edge the state goes to ACCEPT, `beat` clears to 0, `acc_p` and `acc_n` clear to 0, and the operand registers clear to 0.
- While `rst` is high, `in_ready`, `out_valid` and `pc_a` are forced to 0, and `out_sum`/`out_act` read 0.
- States:
  - **ACCEPT**
    - `in_ready` = 1.
    - On `in_valid`, capture `x&wp` into `opp` and `x&wn` into `opn`, then go to POS.
  - **POS**
    - `pc_a` = `opp`.
    - `acc_p <= sat(acc_p + pc_q)`.
    - Go to NEG.
  - **NEG**
    - `pc_a` = `opn`.
    - `acc_n <= sat(acc_n + pc_q)`.
    - If `beat == NBEATS-1`, go to DONE and clear `beat`.
    - Otherwise increment `beat` and go to ACCEPT.
  - **DONE**
    - `out_valid` = 1; outputs are stable.
    - On `out_ready`, clear both accumulators and go to ACCEPT.
- `pc_a` = 0 in ACCEPT and DONE, which suppresses toggling in the printed popcount.
- Arithmetic:
  - `pc_q` is zero-extended to `ACC_W`.
  - `sat()` clamps at 2^ACC_W − 1; it never wraps.
  - `pc_q` values above 25 (possible with approximate units) are accumulated as-is.
- `out_sum` is registered, or combinational from the accumulators; either way it is valid whenever `out_valid` = 1.
- `out_act`:
  - 01 if `out_sum >= THR_HI`.
  - 11 if `out_sum <= THR_LO`.
  - 00 otherwise.
- `in_ready` and `out_valid` are never high together.
- Input data is ignored outside ACCEPT.

## Timing
- Each chunk takes 3 cycles: ACCEPT handshake, POS, NEG.
- A neuron takes 3·NBEATS cycles plus the DONE cycles.
- Latency: if the last chunk handshake is at cycle t, `out_valid` rises at t+3.
- Back-to-back: a DONE handshake at cycle t gives `in_ready` = 1 at t+1.
- `out_ready` held high in DONE costs exactly 1 DONE cycle.
- Backpressure: DONE holds indefinitely with `out_sum`/`out_act` unchanged.
- `in_valid` low in ACCEPT: the block waits and `beat` is preserved.
- Reset mid-operation, in POS, NEG or DONE: the partial neuron is discarded and the block is in ACCEPT with `beat` = 0 at the first cycle after `rst` falls.
- `pc_q` is sampled at the same clock edge that leaves POS or NEG. The external popcount path must meet one cycle.

## Test plan
- Bench settings: `NBEATS`=4, `ACC_W`=8, `THR_HI`=2, `THR_LO`=−2, exact popcount model.
- **Single neuron, mixed weights.** Every beat has `in_x`=all-ones, `in_wp`=0x000001F (5 bits), `in_wn`=0x0000007 (3 bits). Required: `out_sum`=+8 (20−12), `out_act`=01, `out_valid` at 3 cycles after the 4th handshake.
- **Negative and zero bands.**
  - `wp`=0, `wn`=0x1 each beat: `out_sum`=−4, `out_act`=11.
  - `wp`=`wn`=0x3 each beat: `out_sum`=0, `out_act`=00.
  - Threshold edge, `wp`=0x1 on beats 0–1 only: `out_sum`=+2, `out_act`=01.
- **Saturation.**
  - Popcount model forced to return 31: `acc_p` reaches 124 with no overflow.
  - With `ACC_W`=6: `acc_p` clamps at 63 and `out_sum`=+63 when `wn`=0.
- **Handshake stress.**
  - Random `in_valid` gaps and `out_ready` held low for 10 cycles: outputs stable throughout DONE, no chunk lost or duplicated, `in_ready`&`out_valid` never both 1.
  - Back-to-back neurons accepted 1 cycle after the DONE handshake.
- **Reset mid-operation.**
  - Assert `rst` in NEG of beat 2: all outputs 0 during reset.
  - The next neuron (values from the first scenario) gives `out_sum`=+8, with no residue from the aborted neuron.
- **Operand gating.** `pc_a`=0 in every ACCEPT and DONE cycle, and equals `x&wp` then `x&wn` in POS/NEG, checked against captured inputs for 1000 random chunks.
